// File: rtl/cpu_types_pkg.sv
// Types and constants shared by the memory-side blocks of the processor.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIGrant = 2'd1,
    StDGrant = 2'd2
  } arb_state_t;

  localparam logic [31:0] BAD_DATA = 32'hBAD1BAD1;

  // Data wins unless the instruction side has been passed over too many times.
  function automatic arb_state_t arb_select(input logic ireq, input logic dreq,
                                            input logic istarved);
    if (dreq && !(istarved && ireq)) return StDGrant;
    if (ireq) return StIGrant;
    return StIdle;
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Stall counter for a granted RAM access; tc flags the last cycle before abort.
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tc
);
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) cnt_d = '0;
    else if (!tc) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto a single-ported RAM bus.
// Data has priority, a streak limit keeps instruction fetch moving, a watchdog aborts stuck accesses.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready,
  output logic        err
);
  localparam int unsigned SW = ($clog2(MAX_DSTREAK + 1) > 3) ? $clog2(MAX_DSTREAK + 1) : 3;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  arb_state_t    state_q, state_d, sel;
  logic [SW-1:0] dstreak_q, dstreak_d;
  logic          ireq, dreq, in_i, in_d, live_req, complete, timeout;
  logic          wd_tc, wd_clear;

  assign ireq     = iREN;
  assign dreq     = dREN | dWEN;
  assign in_i     = (state_q == StIGrant);
  assign in_d     = (state_q == StDGrant);
  assign live_req = (in_i & ireq) | (in_d & dreq);
  assign complete = live_req & ram_ready;
  // A flushed access is not an abort: the requester already walked away.
  assign timeout  = live_req & wd_tc & ~ram_ready;

  always_comb begin
    dstreak_d = dstreak_q;
    if (!ireq || (in_i && complete)) begin
      dstreak_d = '0;
    end else if (in_d && complete && (dstreak_q != STREAK_MAX)) begin
      dstreak_d = dstreak_q + SW'(1);
    end
  end

  // Arbitrate on the post-update streak so the starvation limit takes effect immediately.
  assign sel = arb_select(ireq, dreq, dstreak_d == STREAK_MAX);

  always_comb begin
    state_d = state_q;
    if (state_q == StIdle) begin
      state_d = sel;
    end else if (!live_req || timeout) begin
      state_d = StIdle;
    end else if (complete) begin
      state_d = sel;
    end
  end

  assign wd_clear = (state_q == StIdle) | ram_ready | (state_d != state_q);

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk  (CLK),
    .rst  (RST),
    .clear(wd_clear),
    .tc   (wd_tc)
  );

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    case (state_q)
      StIGrant: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iload   = timeout ? BAD_DATA : ramload;
      end
      StDGrant: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dload    = timeout ? BAD_DATA : ramload;
      end
      default: ;
    endcase
  end

  assign iwait = ireq & ~(in_i & (complete | timeout));
  assign dwait = dreq & ~(in_d & (complete | timeout));
  assign err   = timeout;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      dstreak_q <= '0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter against a cycle-level behavioural model.
module tb_mem_arbiter;
  localparam int unsigned MAXD = 4;
  localparam int unsigned TO   = 8;
  localparam logic [31:0] BAD  = 32'hBAD1BAD1;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0, ram_ready = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN, err;

  int checks = 0;
  int passed = 0;

  // Model: who holds the bus (0 none, 1 instr, 2 data), data-grant streak, stalled cycles.
  int m_grant = 0, m_streak = 0, m_stall = 0;
  int n_grant = 0, n_streak = 0, n_stall = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(
    .MAX_DSTREAK(MAXD),
    .TIMEOUT    (TO)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iload    (iload),
    .iwait    (iwait),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dload    (dload),
    .dwait    (dwait),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ram_ready(ram_ready),
    .err      (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_grant = 0; m_streak = 0; m_stall = 0;
  endtask

  // Evaluate the model at the falling edge and compare every output.
  task automatic sample();
    logic ir, dr, live, done, tmo;
    logic e_ren, e_wen;
    logic [31:0] e_addr, e_store, e_il, e_dl;
    int pick;
    @(negedge CLK);
    ir   = iREN;
    dr   = dREN | dWEN;
    live = (m_grant == 1 && ir) || (m_grant == 2 && dr);
    done = live && ram_ready;
    tmo  = live && !ram_ready && (m_stall == TO - 1);
    e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0; e_il = '0; e_dl = '0;
    if (m_grant == 1) begin
      e_ren = iREN; e_addr = iaddr; e_il = tmo ? BAD : ramload;
    end else if (m_grant == 2) begin
      e_wen = dWEN; e_ren = dREN && !dWEN; e_addr = daddr; e_store = dstore;
      e_dl = tmo ? BAD : ramload;
    end
    check("ramREN", 32'(ramREN), 32'(e_ren));
    check("ramWEN", 32'(ramWEN), 32'(e_wen));
    check("ramaddr", ramaddr, e_addr);
    check("ramstore", ramstore, e_store);
    check("iload", iload, e_il);
    check("dload", dload, e_dl);
    check("iwait", 32'(iwait), 32'(ir && !(m_grant == 1 && (done || tmo))));
    check("dwait", 32'(dwait), 32'(dr && !(m_grant == 2 && (done || tmo))));
    check("err", 32'(err), 32'(tmo));
    if (!ir || (done && m_grant == 1)) n_streak = 0;
    else if (done && m_grant == 2) n_streak = (m_streak < MAXD) ? m_streak + 1 : MAXD;
    else n_streak = m_streak;
    pick = (dr && !(ir && n_streak == MAXD)) ? 2 : (ir ? 1 : 0);
    if (m_grant == 0) n_grant = pick;
    else if (!live || tmo) n_grant = 0;
    else if (done) n_grant = pick;
    else n_grant = m_grant;
    n_stall = (m_grant != 0 && n_grant == m_grant && !ram_ready) ? m_stall + 1 : 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RST) model_reset();
    else begin
      m_grant = n_grant; m_streak = n_streak; m_stall = n_stall;
    end
    #1;
  endtask

  task automatic cyc();
    sample();
    tick();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    model_reset();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0;
    repeat (2) cyc();
    RST = 1'b0;
  endtask

  initial begin
    int slow;
    // Reset state
    sample();
    check("rst_ramREN", 32'(ramREN), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_dload", dload, 32'd0);
    tick();
    do_reset();

    // Instruction fetch: idle cycle, then grant with completion
    iREN = 1'b1; iaddr = 32'h40;
    sample();
    check("i_c1_ren", 32'(ramREN), 32'd0);
    check("i_c1_iwait", 32'(iwait), 32'd1);
    tick();
    ram_ready = 1'b1; ramload = 32'h1234_5678;
    sample();
    check("i_c2_ren", 32'(ramREN), 32'd1);
    check("i_c2_addr", ramaddr, 32'h40);
    check("i_c2_iload", iload, 32'h1234_5678);
    check("i_c2_iwait", 32'(iwait), 32'd0);
    tick();
    iREN = 1'b0;
    cyc();

    // Write wins over read when both are raised
    dWEN = 1'b1; dREN = 1'b1; daddr = 32'h100; dstore = 32'hCAFE; ram_ready = 1'b0;
    cyc();
    ram_ready = 1'b1;
    sample();
    check("w_wen", 32'(ramWEN), 32'd1);
    check("w_ren", 32'(ramREN), 32'd0);
    check("w_store", ramstore, 32'hCAFE);
    check("w_addr", ramaddr, 32'h100);
    tick();
    dWEN = 1'b0; dREN = 1'b0;
    cyc();

    // Starvation limit: D,D,D,D,I repeating with no idle gaps
    do_reset();
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h40; daddr = 32'h100; ram_ready = 1'b1;
    cyc();
    for (int k = 0; k < 10; k++) begin
      sample();
      check("pattern", ramaddr, (k % 5 == 4) ? 32'h40 : 32'h100);
      tick();
    end
    iREN = 1'b0; dREN = 1'b0;
    cyc();

    // Watchdog abort on a data read
    do_reset();
    dREN = 1'b1; ram_ready = 1'b0; ramload = 32'h5555_AAAA;
    cyc();
    for (int k = 1; k <= int'(TO); k++) begin
      sample();
      check("to_err", 32'(err), 32'(k == int'(TO)));
      if (k == int'(TO)) begin
        check("to_dwait", 32'(dwait), 32'd0);
        check("to_dload", dload, BAD);
      end
      tick();
    end
    sample();
    check("to_err_after", 32'(err), 32'd0);
    check("to_idle_ren", 32'(ramREN), 32'd0);
    tick();
    dREN = 1'b0;
    cyc();

    // Data flush with instruction pending
    do_reset();
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h80; daddr = 32'h200; ram_ready = 1'b0;
    cyc();
    dREN = 1'b0;
    sample();
    check("fl_ren_now", 32'(ramREN), 32'd0);
    tick();
    sample();
    check("fl_idle_ren", 32'(ramREN), 32'd0);
    check("fl_iwait", 32'(iwait), 32'd1);
    tick();
    ram_ready = 1'b1;
    sample();
    check("fl_igrant", 32'(ramREN), 32'd1);
    check("fl_iaddr", ramaddr, 32'h80);
    tick();
    iREN = 1'b0;
    cyc();

    // Reset in the middle of an instruction grant
    iREN = 1'b1; iaddr = 32'hC0; ram_ready = 1'b0;
    cyc();
    sample();
    check("rg_ren", 32'(ramREN), 32'd1);
    RST = 1'b1;
    #1;
    check("rg_ren_rst", 32'(ramREN), 32'd0);
    model_reset();
    tick();
    cyc();
    RST = 1'b0;
    ram_ready = 1'b1;
    cyc();
    sample();
    check("rg_fresh", 32'(ramREN), 32'd1);
    check("rg_fresh_addr", ramaddr, 32'hC0);
    tick();
    iREN = 1'b0;
    cyc();

    // Randomized traffic with occasional long RAM stalls
    slow = 0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 4) == 0) iREN = ~iREN;
      if ($urandom_range(0, 4) == 0) begin
        dREN = 1'($urandom_range(0, 1));
        dWEN = ($urandom_range(0, 2) == 0);
      end
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      if (slow > 0) begin
        ram_ready = 1'b0;
        slow--;
      end else if ($urandom_range(0, 19) == 0) begin
        ram_ready = 1'b0;
        slow = 12;
      end else begin
        ram_ready = ($urandom_range(0, 3) != 0);
      end
      cyc();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
